alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Upstream/downstream wrapper for the 4-bit combinational ALU.
- Buffers incoming operation commands in a small FIFO and presents one command at a time to the ALU through registered operand/opcode outputs.
- Captures result, carry and zero into a response register, which is handed off with a valid/ready handshake.
- Gives the datapath a clean pipelined interface around a purely combinational ALU.

Parameters:
W, 4, operand/result width; must match the ALU.
DEPTH, 2, command FIFO depth; power of two, >=2.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO can accept.
cmd_op  in  4  operator select: 0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 ilt, 7 iet; 8-15 illegal.
cmd_a  in  W  operand A.
cmd_b  in  W  operand B.
alu_a  out  W  registered operand A to ALU dA.
alu_b  out  W  registered operand B to ALU dB.
alu_op  out  4  registered opcode to ALU operator_sel.
alu_result  in  W  ALU result.
alu_carry  in  1  ALU carry.
alu_zero  in  1  ALU zero.
rsp_valid  out  1  response held.
rsp_ready  in  1  consumer accepts.
rsp_result  out  W  captured result.
rsp_carry  out  1  captured carry.
rsp_zero  out  1  captured zero.
rsp_illegal  out  1  opcode was 8-15.
busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset is asynchronous, active-low, on rst_n.
  - All outputs, FIFO pointers/count and state return to 0/IDLE immediately.
  - cmd_ready is 1 once reset is released.
  - Reset mid-operation discards FIFO contents and any pending response; no partial response appears after release.
- Push: at a clock edge where cmd_valid & cmd_ready, write {op,a,b} into the FIFO.
  - cmd_ready = (count < DEPTH), from registered count only; there is no same-cycle pop bypass.
- FSM states: IDLE, EXEC, RESP.
  - IDLE, FIFO non-empty, popped op legal: pop; load alu_a/alu_b/alu_op; go to EXEC.
  - IDLE, FIFO non-empty, popped op illegal: pop; load rsp with result=0, carry=0, zero=0, illegal=1; go to RESP. alu_* are not updated.
  - EXEC, one cycle: at the next edge capture alu_result/carry/zero into rsp_*; set illegal=0; go to RESP.
  - RESP: rsp_valid=1, all rsp_* held stable until an edge with rsp_ready=1. On that edge:
    - FIFO non-empty: pop the next command and go to EXEC (legal) or stay in RESP with the new illegal response loaded.
    - FIFO empty: go to IDLE.
  - rsp_valid=1 only in RESP.
- Latency: legal command accepted at edge E -> popped at E+1 -> rsp_valid from E+2. Illegal command -> rsp_valid from E+1.
- Throughput: one legal op per 2 cycles with rsp_ready tied high.
- alu_a/alu_b/alu_op hold their last loaded values outside EXEC.
- Simultaneous push and pop on one edge: count unchanged, both take effect.
- Push while full is impossible because cmd_ready=0. cmd_ready rises in the cycle after a pop from full.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).
- Arithmetic is the ALU's alone; this block never modifies result bits.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_IET (0-7);
  - the rule that op[3] set means illegal;
  - state encoding IDLE/EXEC/RESP;
  - the command struct/field widths {op[3:0], a[W-1:0], b[W-1:0]}.
- One sub-module, alu_cmd_fifo: synchronous DEPTH-entry FIFO with async active-low reset, push/pop, full/empty and count.
- The FSM and response register stay in alu_issue_stage.

Test Plan:
- Reset release, then add 3+5 at edge E, rsp_ready=1 -> alu_op=0, alu_a=3, alu_b=5 during E+1..E+2; rsp_valid at E+2 with result 8, carry 0, zero 0; busy=0 after handoff.
- Add 4'hF+4'h1 (bench ALU model) -> rsp_result=0, rsp_carry=1, rsp_zero=1.
- rsp_ready=0, offer 4 back-to-back commands:
  - first three accepted (one in RESP, two in FIFO);
  - cmd_ready=0 on the 4th;
  - raising rsp_ready drains responses in order, one per 2 cycles, with rsp_* stable while stalled.
- cmd_op=4'hA -> rsp_valid one edge after pop, rsp_illegal=1, result/carry/zero=0, alu_op unchanged from the prior op.
- Drop rst_n asynchronously while in EXEC with 2 queued commands -> outputs 0 immediately; after release no rsp_valid until new commands arrive; cmd_ready=1.
- Push/pop collision: FIFO count=1 in RESP, rsp_ready=1 and cmd_valid=1 on the same edge -> count stays 1 and the next op enters EXEC.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM encoding and command layout.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_NOT = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_ILT = 4'd6;
  localparam logic [OP_W-1:0] OP_IET = 4'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // Opcodes 8-15 are reserved; the top bit alone identifies them.
  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

  // Packed command layout is {op, a, b}.
  function automatic int unsigned cmd_width(input int unsigned w);
    return OP_W + 2 * w;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
module alu_cmd_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [Width-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [Width-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(Depth+1)-1:0]   o_count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Depth is a power of two, so pointer overflow wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around a combinational ALU: command FIFO, registered operands and a
// valid/ready response register.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [OP_W-1:0] i_cmd_op,
  input  logic [W-1:0]    i_cmd_a,
  input  logic [W-1:0]    i_cmd_b,
  output logic [W-1:0]    o_alu_a,
  output logic [W-1:0]    o_alu_b,
  output logic [OP_W-1:0] o_alu_op,
  input  logic [W-1:0]    i_alu_result,
  input  logic            i_alu_carry,
  input  logic            i_alu_zero,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [W-1:0]    o_rsp_result,
  output logic            o_rsp_carry,
  output logic            o_rsp_zero,
  output logic            o_rsp_illegal,
  output logic            o_busy
);

  localparam int unsigned CMD_W = cmd_width(W);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CMD_W-1:0] w_head;
  logic [OP_W-1:0]  w_head_op;
  logic [W-1:0]     w_head_a;
  logic [W-1:0]     w_head_b;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_head_illegal;

  state_e          r_state;
  state_e          w_state_d;
  logic [W-1:0]    r_alu_a;
  logic [W-1:0]    r_alu_b;
  logic [OP_W-1:0] r_alu_op;
  logic [W-1:0]    r_rsp_result;
  logic            r_rsp_carry;
  logic            r_rsp_zero;
  logic            r_rsp_illegal;

  // Gated by rst_n so cmd_ready reads 0 while reset is held.
  assign o_cmd_ready = rst_n & ~w_full;
  assign w_push      = i_cmd_valid & o_cmd_ready;

  alu_cmd_fifo #(
    .Width (CMD_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({i_cmd_op, i_cmd_a, i_cmd_b}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign {w_head_op, w_head_a, w_head_b} = w_head;
  assign w_head_illegal = op_is_illegal(w_head_op);

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = w_head_illegal ? StResp : StExec;
        end
      end
      StExec: w_state_d = StResp;
      StResp: begin
        if (i_rsp_ready) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_d = w_head_illegal ? StResp : StExec;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_rsp_result  <= '0;
      r_rsp_carry   <= 1'b0;
      r_rsp_zero    <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_pop && !w_head_illegal) begin
        r_alu_a  <= w_head_a;
        r_alu_b  <= w_head_b;
        r_alu_op <= w_head_op;
      end
      // Illegal ops bypass the ALU and produce a canned response directly.
      if (w_pop && w_head_illegal) begin
        r_rsp_result  <= '0;
        r_rsp_carry   <= 1'b0;
        r_rsp_zero    <= 1'b0;
        r_rsp_illegal <= 1'b1;
      end else if (r_state == StExec) begin
        r_rsp_result  <= i_alu_result;
        r_rsp_carry   <= i_alu_carry;
        r_rsp_zero    <= i_alu_zero;
        r_rsp_illegal <= 1'b0;
      end
    end
  end

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_rsp_valid   = (r_state == StResp);
  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_carry   = r_rsp_carry;
  assign o_rsp_zero    = r_rsp_zero;
  assign o_rsp_illegal = r_rsp_illegal;
  assign o_busy        = (r_state != StIdle) | (w_fifo_count != '0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and a response queue model.
module tb_alu_issue_stage;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_illegal;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Expected responses in order, packed {illegal, zero, carry, result}.
  logic [6:0] exp_q[$];
  logic [6:0] rsp_obs;

  assign rsp_obs = {rsp_illegal, rsp_zero, rsp_carry, rsp_result};

  function automatic logic [4:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, ~a};
      4'd3:    return {1'b0, a & b};
      4'd4:    return {1'b0, a | b};
      4'd5:    return {1'b0, a ^ b};
      4'd6:    return {4'b0, (a < b)};
      4'd7:    return {4'b0, (a == b)};
      default: return 5'b0;
    endcase
  endfunction

  function automatic logic [6:0] expect_rsp(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
    logic [4:0] r;
    if (op >= 4'd8) return 7'h40;
    r = alu_fn(op, a, b);
    return {1'b0, (r[3:0] == 4'd0), r[4], r[3:0]};
  endfunction

  assign {alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_result == 4'd0);

  alu_issue_stage #(
    .W     (4),
    .DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_a       (cmd_a),
    .i_cmd_b       (cmd_b),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .o_alu_op      (alu_op),
    .i_alu_result  (alu_result),
    .i_alu_carry   (alu_carry),
    .i_alu_zero    (alu_zero),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_result  (rsp_result),
    .o_rsp_carry   (rsp_carry),
    .o_rsp_zero    (rsp_zero),
    .o_rsp_illegal (rsp_illegal),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic v, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_cmd(1'b0, 4'd0, 4'd0, 4'd0);
    rsp_ready = 1'b0;
    tick();
    tick();
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
    end
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid_busy: got %b expected 00", {rsp_valid, busy});
    end
    n_tests++;
    if ({alu_op, alu_a, alu_b, rsp_obs} !== 19'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h expected 0", {alu_op, alu_a, alu_b, rsp_obs});
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready);
    end
    tick();
  endtask

  task automatic test_basic_add();
    rsp_ready = 1'b1;
    set_cmd(1'b1, 4'd0, 4'd3, 4'd5);
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({rsp_valid, busy} !== 2'b01) begin
      n_fail++; $display("FAIL add_e0_state: got %b expected 01", {rsp_valid, busy});
    end
    tick();
    n_tests++;
    if ({alu_op, alu_a, alu_b, rsp_valid} !== {4'd0, 4'd3, 4'd5, 1'b0}) begin
      n_fail++; $display("FAIL add_e1_operands: got %h expected %h",
                         {alu_op, alu_a, alu_b, rsp_valid}, {4'd0, 4'd3, 4'd5, 1'b0});
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_obs} !== {1'b1, 7'h08}) begin
      n_fail++; $display("FAIL add_e2_response: got %h expected %h", {rsp_valid, rsp_obs},
                         {1'b1, 7'h08});
    end
    n_tests++;
    if ({alu_a, alu_b} !== 8'h35) begin
      n_fail++; $display("FAIL add_e2_operands_held: got %h expected 35", {alu_a, alu_b});
    end
    tick();
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL add_after_handoff: got %b expected 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_carry_zero();
    int k;
    rsp_ready = 1'b1;
    set_cmd(1'b1, 4'd0, 4'hF, 4'h1);
    tick();
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin
      tick();
      k++;
    end
    n_tests++;
    if ({rsp_valid, rsp_obs} !== {1'b1, 7'h30}) begin
      n_fail++; $display("FAIL carry_zero: got %h expected %h", {rsp_valid, rsp_obs},
                         {1'b1, 7'h30});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[4];
    logic [3:0] as[4];
    logic [3:0] bs[4];
    int last_hs;
    int k;
    exp_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ops[i] = 4'($urandom_range(0, 7));
      as[i]  = 4'($urandom);
      bs[i]  = 4'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, ops[i], as[i], bs[i]);
      n_tests++;
      if (cmd_ready !== (i < 3)) begin
        n_fail++; $display("FAIL b2b_ready_%0d: got %b expected %b", i, cmd_ready, (i < 3));
      end
      if (i < 3) begin
        exp_q.push_back(expect_rsp(ops[i], as[i], bs[i]));
        tick();
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({cmd_ready, rsp_valid, rsp_obs} !== {2'b01, exp_q[0]}) begin
        n_fail++; $display("FAIL b2b_stall_%0d: got %h expected %h", i,
                           {cmd_ready, rsp_valid, rsp_obs}, {2'b01, exp_q[0]});
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    last_hs = -1;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      if (rsp_valid) begin
        n_tests++;
        if (rsp_obs !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_drain_data: got %h expected %h", rsp_obs, exp_q[0]);
        end
        if (last_hs >= 0) begin
          n_tests++;
          if (cycle - last_hs != 2) begin
            n_fail++; $display("FAIL b2b_drain_spacing: got %0d expected 2", cycle - last_hs);
          end
        end
        last_hs = cycle;
        void'(exp_q.pop_front());
      end
      tick();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain_done: got left=%0d busy=%b expected 0/0",
                         exp_q.size(), busy);
    end
  endtask

  task automatic test_illegal();
    int k;
    rsp_ready = 1'b1;
    set_cmd(1'b1, 4'd5, 4'hC, 4'h6);
    tick();
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin
      tick();
      k++;
    end
    tick();
    rsp_ready = 1'b0;
    set_cmd(1'b1, 4'hA, 4'h7, 4'h7);
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_early: got %b expected 0", rsp_valid);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({rsp_valid, rsp_obs, alu_op} !== {1'b1, 7'h40, 4'd5}) begin
        n_fail++; $display("FAIL illegal_rsp_%0d: got %h expected %h", i,
                           {rsp_valid, rsp_obs, alu_op}, {1'b1, 7'h40, 4'd5});
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_handoff: got %b expected 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1'b0;
    set_cmd(1'b1, 4'd4, 4'h9, 4'h2);
    tick();
    set_cmd(1'b1, 4'd3, 4'hE, 4'h7);
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({rsp_valid, busy, alu_a} !== {2'b01, 4'h9}) begin
      n_fail++; $display("FAIL midop_exec: got %h expected %h", {rsp_valid, busy, alu_a},
                         {2'b01, 4'h9});
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cmd_ready, rsp_valid, busy, alu_op, alu_a, alu_b, rsp_obs} !== 22'h0) begin
      n_fail++; $display("FAIL midop_async_clear: got %h expected 0",
                         {cmd_ready, rsp_valid, busy, alu_op, alu_a, alu_b, rsp_obs});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
        n_fail++; $display("FAIL midop_after_release_%0d: got %b expected 100", i,
                           {cmd_ready, rsp_valid, busy});
      end
    end
    exp_q.delete();
  endtask

  task automatic test_collision();
    int k;
    exp_q.delete();
    rsp_ready = 1'b0;
    set_cmd(1'b1, 4'd1, 4'h2, 4'h5);
    exp_q.push_back(expect_rsp(4'd1, 4'h2, 4'h5));
    tick();
    set_cmd(1'b1, 4'd6, 4'h3, 4'hB);
    exp_q.push_back(expect_rsp(4'd6, 4'h3, 4'hB));
    tick();
    cmd_valid = 1'b0;
    tick();
    n_tests++;
    if ({dut.w_fifo_count, rsp_valid, rsp_obs} !== {2'd1, 1'b1, exp_q[0]}) begin
      n_fail++; $display("FAIL coll_setup: got %h expected %h",
                         {dut.w_fifo_count, rsp_valid, rsp_obs}, {2'd1, 1'b1, exp_q[0]});
    end
    void'(exp_q.pop_front());
    rsp_ready = 1'b1;
    set_cmd(1'b1, 4'd2, 4'h6, 4'h1);
    exp_q.push_back(expect_rsp(4'd2, 4'h6, 4'h1));
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({dut.w_fifo_count, rsp_valid, alu_op, alu_a, alu_b} !==
        {2'd1, 1'b0, 4'd6, 4'h3, 4'hB}) begin
      n_fail++; $display("FAIL coll_count_exec: got %h expected %h",
                         {dut.w_fifo_count, rsp_valid, alu_op, alu_a, alu_b},
                         {2'd1, 1'b0, 4'd6, 4'h3, 4'hB});
    end
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      if (rsp_valid) begin
        n_tests++;
        if (rsp_obs !== exp_q[0]) begin
          n_fail++; $display("FAIL coll_drain: got %h expected %h", rsp_obs, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL coll_drain_timeout: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    logic       pend;
    logic [3:0] p_op;
    logic [3:0] p_a;
    logic [3:0] p_b;
    int         k;
    exp_q.delete();
    pend = 1'b0;
    p_op = '0;
    p_a  = '0;
    p_b  = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        p_op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7))
                                           : 4'($urandom_range(0, 7));
        p_a  = 4'($urandom);
        p_b  = 4'($urandom);
      end
      set_cmd(pend, p_op, p_a, p_b);
      rsp_ready = ($urandom_range(0, 3) != 0);
      n_tests++;
      if (busy !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL rand_busy: got %b expected %b", busy, (exp_q.size() != 0));
      end
      if (rsp_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious_rsp: got %h expected none", rsp_obs);
        end else begin
          if (rsp_obs !== exp_q[0]) begin
            n_fail++; $display("FAIL rand_rsp: got %h expected %h", rsp_obs, exp_q[0]);
          end
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (pend && cmd_ready) begin
        exp_q.push_back(expect_rsp(p_op, p_a, p_b));
        pend = 1'b0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      if (rsp_valid) begin
        n_tests++;
        if (rsp_obs !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_drain: got %h expected %h", rsp_obs, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rand_drain_done: got left=%0d busy=%b expected 0/0",
                         exp_q.size(), busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_add();
    test_carry_zero();
    test_back_to_back();
    test_illegal();
    test_reset_midop();
    test_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
